// File: rtl/cpu_step_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_step_ctrl: run/pause/single-step controller for the MIPS core.           |
// | Debounces run/step buttons on tick_in and issues 1-cycle cpu_en strobes.     |
// | Optional breakpoint halt when CPU_STEP_BREAKPOINT_EN is defined.             |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module cpu_step_ctrl #(
  parameter int unsigned DB_TICKS = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned PC_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             btn_run,
  input  logic             btn_step,
  output logic             cpu_en,
  output logic             running,
  output logic [CNT_W-1:0] step_cnt
`ifdef CPU_STEP_BREAKPOINT_EN
  ,
  input  logic [PC_W-1:0]  pc_in,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic             bp_valid,
  output logic             bp_hit
`endif
);

  localparam int unsigned           c_DBC_W   = $clog2(DB_TICKS);
  localparam logic [c_DBC_W-1:0]    c_DBC_MAX = c_DBC_W'(DB_TICKS - 1);

  typedef enum logic [1:0] {
    ST_PAUSE     = 2'd0,
    ST_RUN       = 2'd1,
    ST_STEP_WAIT = 2'd2
  } state_t;

  state_t     r_state;
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] w_press;
  logic       w_run_p;
  logic       w_step_p;
  logic       w_tick_ok;
  logic       w_bp_stop;
  logic       w_issue;
  logic       w_halt;

  // Bit 0 is the run button, bit 1 the step button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= {btn_step, btn_run};
      r_sync2 <= r_sync1;
    end
  end

  generate
    for (genvar b = 0; b < 2; b++) begin : g_db
      logic               r_stable;
      logic [c_DBC_W-1:0] r_dbc;
      logic               w_diff;

      assign w_diff     = r_sync2[b] ^ r_stable;
      // Press pulse coincides with the tick that accepts the 0->1 change.
      assign w_press[b] = tick_in & w_diff & (r_dbc == c_DBC_MAX) & ~r_stable;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_stable <= 1'b0;
          r_dbc    <= '0;
        end else if (tick_in) begin
          if (!w_diff) begin
            r_dbc <= '0;
          end else if (r_dbc == c_DBC_MAX) begin
            r_stable <= ~r_stable;
            r_dbc    <= '0;
          end else begin
            r_dbc <= r_dbc + c_DBC_W'(1);
          end
        end
      end
    end
  endgenerate

  assign w_run_p   = w_press[0];
  assign w_step_p  = w_press[1];
  assign w_tick_ok = tick_in & ~cpu_en;

`ifdef CPU_STEP_BREAKPOINT_EN
  logic r_skip;

  assign w_bp_stop = bp_valid & (pc_in == bp_addr) & ~r_skip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp_hit <= 1'b0;
      r_skip <= 1'b0;
    end else begin
      if (w_run_p) begin
        bp_hit <= 1'b0;
      end else if (w_halt) begin
        bp_hit <= 1'b1;
      end
      // First enable after a resume must not re-trigger on the same PC.
      if (w_run_p && (r_state != ST_RUN)) begin
        r_skip <= 1'b1;
      end else if (w_issue) begin
        r_skip <= 1'b0;
      end
    end
  end
`else
  assign w_bp_stop = 1'b0;
`endif

  assign w_issue = ~w_run_p & w_tick_ok &
                   (((r_state == ST_RUN) & ~w_bp_stop) | (r_state == ST_STEP_WAIT));
  assign w_halt  = ~w_run_p & w_tick_ok & (r_state == ST_RUN) & w_bp_stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_PAUSE;
      cpu_en   <= 1'b0;
      running  <= 1'b0;
      step_cnt <= '0;
    end else begin
      cpu_en <= w_issue;
      if (w_issue) begin
        step_cnt <= step_cnt + CNT_W'(1);
      end
      case (r_state)
        ST_PAUSE: begin
          if (w_run_p) begin
            r_state <= ST_RUN;
            running <= 1'b1;
          end else if (w_step_p) begin
            r_state <= ST_STEP_WAIT;
          end
        end
        ST_STEP_WAIT: begin
          if (w_run_p) begin
            r_state <= ST_RUN;
            running <= 1'b1;
          end else if (w_issue) begin
            r_state <= ST_PAUSE;
          end
        end
        ST_RUN: begin
          if (w_run_p || w_halt) begin
            r_state <= ST_PAUSE;
            running <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_PAUSE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_step_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cpu_step_ctrl: table-driven bench with cpu_en scoreboard for            |
// | cpu_step_ctrl (tick every 10 clk, DB_TICKS=4, CNT_W=4).                    |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_cpu_step_ctrl;

  localparam int CNT_W    = 4;
  localparam int DB_TICKS = 4;

  logic             clk      = 1'b0;
  logic             rst      = 1'b1;
  logic             tick_in  = 1'b0;
  logic             btn_run  = 1'b0;
  logic             btn_step = 1'b0;
  logic             cpu_en;
  logic             running;
  logic [CNT_W-1:0] step_cnt;
`ifdef CPU_STEP_BREAKPOINT_EN
  logic [31:0]      pc_in    = 32'h0;
  logic [31:0]      bp_addr  = 32'h0;
  logic             bp_valid = 1'b0;
  logic             bp_hit;
`endif

  cpu_step_ctrl #(
    .DB_TICKS (DB_TICKS),
    .CNT_W    (CNT_W),
    .PC_W     (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_in  (tick_in),
    .btn_run  (btn_run),
    .btn_step (btn_step),
    .cpu_en   (cpu_en),
    .running  (running),
    .step_cnt (step_cnt)
`ifdef CPU_STEP_BREAKPOINT_EN
    ,
    .pc_in    (pc_in),
    .bp_addr  (bp_addr),
    .bp_valid (bp_valid),
    .bp_hit   (bp_hit)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    ticks;
    logic  run;
    logic  step;
    int    en_first;
    int    en_last;
    logic  exp_running;
  } vec_t;

  vec_t tbl[$];
  int   cyc       = 0;
  int   n_tests   = 0;
  int   n_fail    = 0;
  int   model_cnt = 0;
  int   exp_q[$];
  int   obs_q[$];
  logic prev_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every observed enable goes to the scoreboard; back-to-back enables are illegal.
  always @(negedge clk) begin
    if (!rst && cpu_en) begin
      obs_q.push_back(cyc);
      n_tests++;
      if (prev_en) begin
        n_fail++;
        $display("FAIL en_consec: cpu_en high at cycles %0d and %0d, required single-cycle", cyc - 1, cyc);
      end
    end
    prev_en <= cpu_en & ~rst;
  end

  function automatic vec_t mk(input string n, input int t, input logic r, input logic s,
                              input int ef, input int el, input logic er);
    vec_t v;
    v.name = n; v.ticks = t; v.run = r; v.step = s;
    v.en_first = ef; v.en_last = el; v.exp_running = er;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name);
    int e;
    int o;
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        o = obs_q.pop_front();
        n_fail++;
        $display("FAIL %s_en: cpu_en at cycle %0d, expected none", name, o);
      end else if (obs_q.size() == 0) begin
        e = exp_q.pop_front();
        n_fail++;
        $display("FAIL %s_en: no cpu_en, expected at cycle %0d", name, e);
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        if (e != o) begin
          n_fail++;
          $display("FAIL %s_en: cpu_en at cycle %0d, expected cycle %0d", name, o, e);
        end
      end
    end
  endtask

  // One tick period = 10 clk; buttons change 5 clk before the tick so they are synchronised.
  task automatic apply_vec(input vec_t v);
    for (int i = 0; i < v.ticks; i++) begin
      btn_run  = v.run;
      btn_step = v.step;
      repeat (5) begin @(posedge clk); #1; end
      tick_in = 1'b1;
      if (i >= v.en_first && i <= v.en_last) begin
        exp_q.push_back(cyc + 1);
        model_cnt++;
      end
      @(posedge clk); #1;
      tick_in = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
    end
    sb_check(v.name);
    chk({v.name, "_running"}, int'(running), int'(v.exp_running));
    chk({v.name, "_cnt"}, int'(step_cnt), model_cnt % (1 << CNT_W));
  endtask

  initial begin
    tbl.push_back(mk("idle",      20, 1'b0, 1'b0, -1, -1, 1'b0));
    tbl.push_back(mk("run_db",     3, 1'b1, 1'b0, -1, -1, 1'b0));
    tbl.push_back(mk("run_on",     3, 1'b1, 1'b0,  1,  2, 1'b1));
    tbl.push_back(mk("run_rel",    3, 1'b0, 1'b0,  0,  2, 1'b1));
    tbl.push_back(mk("run_wrap",  12, 1'b0, 1'b0,  0, 11, 1'b1));
    tbl.push_back(mk("pause",      4, 1'b1, 1'b0,  0,  2, 1'b0));
    tbl.push_back(mk("pause_rel",  4, 1'b0, 1'b0, -1, -1, 1'b0));
    for (int k = 0; k < 5; k++) begin
      tbl.push_back(mk($sformatf("bounce%0d", k), 2, 1'b0, ((k % 2) == 0), -1, -1, 1'b0));
    end
    tbl.push_back(mk("bounce_end", 2, 1'b0, 1'b0, -1, -1, 1'b0));
    tbl.push_back(mk("step_press", 4, 1'b0, 1'b1, -1, -1, 1'b0));
    tbl.push_back(mk("step_go",    2, 1'b0, 1'b0,  0,  0, 1'b0));
    tbl.push_back(mk("step_rel",   2, 1'b0, 1'b0, -1, -1, 1'b0));

    repeat (3) @(posedge clk);
    #1;
    chk("reset_en", int'(cpu_en), 0);
    chk("reset_running", int'(running), 0);
    chk("reset_cnt", int'(step_cnt), 0);
    rst = 1'b0;

    foreach (tbl[k]) apply_vec(tbl[k]);

`ifdef CPU_STEP_BREAKPOINT_EN
    apply_vec(mk("bp_run", 4, 1'b1, 1'b0, -1, -1, 1'b1));
    apply_vec(mk("bp_first", 1, 1'b1, 1'b0, 0, 0, 1'b1));
    bp_valid = 1'b1;
    bp_addr  = 32'h40;
    pc_in    = 32'h40;
    apply_vec(mk("bp_halt", 1, 1'b1, 1'b0, -1, -1, 1'b0));
    chk("bp_hit_set", int'(bp_hit), 1);
    apply_vec(mk("bp_rel", 4, 1'b0, 1'b0, -1, -1, 1'b0));
    chk("bp_hit_sticky", int'(bp_hit), 1);
    apply_vec(mk("bp_resume", 4, 1'b1, 1'b0, -1, -1, 1'b1));
    chk("bp_hit_clr", int'(bp_hit), 0);
    apply_vec(mk("bp_skip", 1, 1'b1, 1'b0, 0, 0, 1'b1));
    apply_vec(mk("bp_again", 1, 1'b1, 1'b0, -1, -1, 1'b0));
    chk("bp_hit_again", int'(bp_hit), 1);
    bp_valid = 1'b0;
    apply_vec(mk("bp_rel2", 4, 1'b0, 1'b0, -1, -1, 1'b0));
`endif

    // Asynchronous reset while an enable is on the wire.
    apply_vec(mk("rst_run", 4, 1'b1, 1'b0, -1, -1, 1'b1));
    tick_in = 1'b1;
    @(posedge clk); #1;
    chk("rst_pre_en", int'(cpu_en), 1);
    #1;
    tick_in = 1'b0;
    rst     = 1'b1;
    #1;
    chk("rst_async_en", int'(cpu_en), 0);
    chk("rst_async_running", int'(running), 0);
    chk("rst_async_cnt", int'(step_cnt), 0);
    model_cnt = 0;
    btn_run   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    apply_vec(mk("post_rst", 3, 1'b0, 1'b0, -1, -1, 1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
